spi_mem_responder: RTL

- Serial memory responder at the far end of the team's SPI link; the target that the existing SPI controller talks to.
- Runs on the same system clock as the controller, with no separate SCLK. It samples mosi and drives miso once per clk while cs is low (cs idles high).
- Decodes a 1-bit opcode and an 8-bit address, then either stores an 8-bit write payload or returns 8 read bits.
- Pulses ready ahead of read data and op_done at frame end, matching the controller's 1-cycle pulse expectations.

---
 rtl/spi_pkg.sv | 28 ++
 rtl/spi_mem_array.sv | 35 +++
 rtl/spi_mem_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI memory responder and its storage array.
package spi_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Counter value marking the last bit of an 8-bit field
    localparam logic [2:0] CNT_LAST = 3'd7;

    localparam logic OP_WRITE = 1'b1;
    localparam logic OP_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_WRITE = 3'd3,
        ST_RLOAD = 3'd4,
        ST_SEND  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // Index width needed to address 'depth' words (at least one bit)
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/spi_mem_array.sv
// Storage for the responder: one write port, combinational read port.
// Address range checking is the responder's job; this array is 2**AW words.
module spi_mem_array
    import spi_pkg::*;
#(
    parameter int                AW      = 5,
    parameter logic [DATA_W-1:0] RST_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int NWORDS = 2 ** AW;

    logic [DATA_W-1:0] mem_q [NWORDS];

    // Storage words: reset to RST_VAL, written one word per cycle when we is set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NWORDS; i++) begin
                mem_q[i] <= RST_VAL;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/spi_mem_responder.sv
// SPI-link memory target: decodes op/address frames on the system clock,
// stores write payloads and returns read data LSB first on miso.
module spi_mem_responder
    import spi_pkg::*;
#(
    parameter int                DEPTH   = 32,
    parameter logic [DATA_W-1:0] RST_VAL = 8'h00
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic mosi,
    output logic miso,
    output logic ready,
    output logic op_done,
    output logic addr_err
);

    localparam int         AW      = idx_width(DEPTH);
    // Full 8-bit address compared against DEPTH with one extra bit so 256 fits
    localparam logic [8:0] DEPTH_9 = 9'(DEPTH);

    state_e state_q, state_d;

    logic [2:0]        cnt_q, cnt_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic              err_q, err_d;
    logic              miso_q, miso_d;
    logic              ready_q, ready_d;
    logic              op_done_q, op_done_d;
    logic              addr_err_q, addr_err_d;

    logic              mem_we_s;
    logic [DATA_W-1:0] mem_rdata_s;
    logic              addr_ok_s;

    assign addr_ok_s = ({1'b0, addr_q} < DEPTH_9);

    spi_mem_array #(
        .AW      (AW),
        .RST_VAL (RST_VAL)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we_s),
        .waddr (addr_q[AW-1:0]),
        .wdata (sreg_q),
        .raddr (addr_q[AW-1:0]),
        .rdata (mem_rdata_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; cs aborts only the shifting states
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!cs) state_d = ST_ADDR;
                else     state_d = ST_IDLE;
            end
            ST_ADDR: begin
                if (cs)                     state_d = ST_IDLE;
                else if (cnt_q == CNT_LAST) state_d = (op_q == OP_WRITE) ? ST_WDATA : ST_RLOAD;
                else                        state_d = ST_ADDR;
            end
            ST_WDATA: begin
                if (cs)                     state_d = ST_IDLE;
                else if (cnt_q == CNT_LAST) state_d = ST_WRITE;
                else                        state_d = ST_WDATA;
            end
            ST_WRITE: state_d = ST_DONE;
            ST_RLOAD: state_d = ST_SEND;
            ST_SEND: begin
                if (cs)                     state_d = ST_IDLE;
                else if (cnt_q == CNT_LAST) state_d = ST_DONE;
                else                        state_d = ST_SEND;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered-output next values per state
    always_comb begin
        cnt_d      = cnt_q;
        op_d       = op_q;
        addr_d     = addr_q;
        sreg_d     = sreg_q;
        err_d      = err_q;
        miso_d     = 1'b0;
        ready_d    = 1'b0;
        op_done_d  = 1'b0;
        addr_err_d = 1'b0;
        mem_we_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 3'd0;
                err_d = 1'b0;
                if (!cs) op_d = mosi;
                else     op_d = op_q;
            end
            ST_ADDR: begin
                if (cs) begin
                    cnt_d = 3'd0;
                end else begin
                    addr_d = {mosi, addr_q[ADDR_W-1:1]};
                    cnt_d  = cnt_q + 3'd1;
                end
            end
            ST_WDATA: begin
                if (cs) begin
                    cnt_d = 3'd0;
                end else begin
                    sreg_d = {mosi, sreg_q[DATA_W-1:1]};
                    cnt_d  = cnt_q + 3'd1;
                end
            end
            ST_WRITE: begin
                cnt_d = 3'd0;
                if (addr_ok_s) mem_we_s = 1'b1;
                else           err_d    = 1'b1;
            end
            ST_RLOAD: begin
                cnt_d   = 3'd0;
                ready_d = 1'b1;
                if (addr_ok_s) begin
                    sreg_d = mem_rdata_s;
                    err_d  = 1'b0;
                end else begin
                    sreg_d = 8'h00;
                    err_d  = 1'b1;
                end
            end
            ST_SEND: begin
                if (cs) begin
                    cnt_d = 3'd0;
                    err_d = 1'b0;
                end else begin
                    miso_d = sreg_q[0];
                    sreg_d = {1'b0, sreg_q[DATA_W-1:1]};
                    cnt_d  = cnt_q + 3'd1;
                end
            end
            ST_DONE: begin
                cnt_d      = 3'd0;
                op_done_d  = 1'b1;
                addr_err_d = err_q;
                err_d      = 1'b0;
            end
            default: begin
                cnt_d = 3'd0;
                err_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= 3'd0;
            op_q       <= OP_READ;
            addr_q     <= 8'h00;
            sreg_q     <= 8'h00;
            err_q      <= 1'b0;
            miso_q     <= 1'b0;
            ready_q    <= 1'b0;
            op_done_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            sreg_q     <= sreg_d;
            err_q      <= err_d;
            miso_q     <= miso_d;
            ready_q    <= ready_d;
            op_done_q  <= op_done_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign miso     = miso_q;
    assign ready    = ready_q;
    assign op_done  = op_done_q;
    assign addr_err = addr_err_q;

endmodule
